// File: rtl/apb_slave_regbank_if.sv
// APB bus bundle between the team's APB master FSM and the register-bank completer.
// o_dbg_state mirrors the completer FSM state (0 = IDLE, 1 = ACCESS) for checkers.
interface apb_slave_regbank_if #(
    parameter int ADDR_W = 32
);
    // Handshake: a transfer is a setup cycle (psel=1, penable=0) followed by access
    // cycles (psel=1, penable=1); it completes in the access cycle where o_pready=1,
    // and o_prdata/o_pslverr are meaningful only in that cycle.
    logic              i_psel;
    logic              i_penable;
    logic              i_pwrite;
    logic [ADDR_W-1:0] i_paddr;
    logic [31:0]       i_pwdata;
    logic              o_pready;
    logic [31:0]       o_prdata;
    logic              o_pslverr;
    logic              o_dbg_state;

    modport master (
        output i_psel, i_penable, i_pwrite, i_paddr, i_pwdata,
        input  o_pready, o_prdata, o_pslverr, o_dbg_state
    );

    modport slave (
        input  i_psel, i_penable, i_pwrite, i_paddr, i_pwdata,
        output o_pready, o_prdata, o_pslverr, o_dbg_state
    );
endinterface

// File: rtl/apb_slave_regbank.sv
// APB completer with a bank of 32-bit registers, programmable wait states and PSLVERR.
// Register 0 is a read-only ID; registers 1..NUM_REGS-1 are read/write and exported on o_regs.
module apb_slave_regbank #(
    parameter int          NUM_REGS    = 8,
    parameter int          ADDR_W      = 32,
    parameter int          WAIT_STATES = 0,
    parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
    input  logic                   i_clk_apb,
    input  logic                   i_rst_apb,
    apb_slave_regbank_if.slave     apb,
    output logic [NUM_REGS*32-1:0] o_regs
);
    localparam int IW = ADDR_W - 2;

    typedef enum logic {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              write_q, write_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       regs_q [1:NUM_REGS-1];
    logic [31:0]       regs_d [1:NUM_REGS-1];

    logic [IW-1:0]     idx;
    logic              dec_err;
    logic [31:0]       rd_word;
    logic              complete;
    logic              violation;

    // Decode always works from the address latched in the setup phase.
    always_comb begin
        idx     = addr_q[ADDR_W-1:2];
        dec_err = (addr_q[1:0] != 2'b00) || (idx >= IW'(NUM_REGS)) || (write_q && (idx == '0));
        rd_word = '0;
        if (idx == '0) begin
            rd_word = ID_VALUE;
        end
        for (int k = 1; k < NUM_REGS; k++) begin
            if (idx == IW'(k)) begin
                rd_word = regs_q[k];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        write_d   = write_q;
        wdata_d   = wdata_q;
        regs_d    = regs_q;
        complete  = 1'b0;
        violation = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (apb.i_psel && !apb.i_penable) begin
                    addr_d  = apb.i_paddr;
                    write_d = apb.i_pwrite;
                    wdata_d = apb.i_pwdata;
                    cnt_d   = 4'(WAIT_STATES);
                    state_d = S_ACCESS;
                end else if (apb.i_psel && apb.i_penable) begin
                    violation = 1'b1;
                end
            end
            S_ACCESS: begin
                if (!apb.i_psel) begin
                    state_d = S_IDLE;
                end else if (apb.i_penable) begin
                    if (cnt_q != 4'd0) begin
                        cnt_d = cnt_q - 4'd1;
                    end else begin
                        complete = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (complete && write_q && !dec_err) begin
            for (int k = 1; k < NUM_REGS; k++) begin
                if (idx == IW'(k)) begin
                    regs_d[k] = wdata_q;
                end
            end
        end
    end

    // Reset masks the response so an aborted transfer never reports completion.
    always_comb begin
        apb.o_pready    = !i_rst_apb && (complete || violation);
        apb.o_pslverr   = !i_rst_apb && (violation || (complete && dec_err));
        apb.o_prdata    = (!i_rst_apb && complete && !write_q && !dec_err) ? rd_word : 32'h0;
        apb.o_dbg_state = state_q;
    end

    always_comb begin
        o_regs        = '0;
        o_regs[31:0]  = ID_VALUE;
        for (int k = 1; k < NUM_REGS; k++) begin
            o_regs[32*k +: 32] = regs_q[k];
        end
    end

    always_ff @(posedge i_clk_apb) begin
        if (i_rst_apb) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= 32'h0;
            for (int k = 1; k < NUM_REGS; k++) begin
                regs_q[k] <= 32'h0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            regs_q  <= regs_d;
        end
    end
endmodule

// File: tb/tb_apb_slave_regbank.sv
// Directed bench for apb_slave_regbank: three instances with WAIT_STATES 0, 3 and 2
// share one clock and reset; expected values are hand-computed constants.
module tb_apb_slave_regbank;
    localparam int          NR = 8;
    localparam int          AW = 32;
    localparam logic [31:0] ID = 32'hA9B0_0001;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    apb_slave_regbank_if #(.ADDR_W(AW)) if0 ();
    apb_slave_regbank_if #(.ADDR_W(AW)) if1 ();
    apb_slave_regbank_if #(.ADDR_W(AW)) if2 ();
    logic [NR*32-1:0] regs0, regs1, regs2;

    apb_slave_regbank #(.NUM_REGS(NR), .ADDR_W(AW), .WAIT_STATES(0), .ID_VALUE(ID)) u_dut0 (
        .i_clk_apb(clk), .i_rst_apb(rst), .apb(if0), .o_regs(regs0));
    apb_slave_regbank #(.NUM_REGS(NR), .ADDR_W(AW), .WAIT_STATES(3), .ID_VALUE(ID)) u_dut1 (
        .i_clk_apb(clk), .i_rst_apb(rst), .apb(if1), .o_regs(regs1));
    apb_slave_regbank #(.NUM_REGS(NR), .ADDR_W(AW), .WAIT_STATES(2), .ID_VALUE(ID)) u_dut2 (
        .i_clk_apb(clk), .i_rst_apb(rst), .apb(if2), .o_regs(regs2));

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input int d, input logic psel, input logic pen, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata);
        case (d)
            0: begin if0.i_psel = psel; if0.i_penable = pen; if0.i_pwrite = wr; if0.i_paddr = addr; if0.i_pwdata = wdata; end
            1: begin if1.i_psel = psel; if1.i_penable = pen; if1.i_pwrite = wr; if1.i_paddr = addr; if1.i_pwdata = wdata; end
            default: begin if2.i_psel = psel; if2.i_penable = pen; if2.i_pwrite = wr; if2.i_paddr = addr; if2.i_pwdata = wdata; end
        endcase
    endtask

    task automatic sample(input int d, output logic rdy, output logic [31:0] rd, output logic err,
                          output logic st, output logic [NR*32-1:0] regs);
        case (d)
            0: begin rdy = if0.o_pready; rd = if0.o_prdata; err = if0.o_pslverr; st = if0.o_dbg_state; regs = regs0; end
            1: begin rdy = if1.o_pready; rd = if1.o_prdata; err = if1.o_pslverr; st = if1.o_dbg_state; regs = regs1; end
            default: begin rdy = if2.o_pready; rd = if2.o_prdata; err = if2.o_pslverr; st = if2.o_dbg_state; regs = regs2; end
        endcase
    endtask

    // One transfer: setup cycle, then access cycles until pready (bounded).
    task automatic xfer(input int d, input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int waits);
        logic             rdy, st, e;
        logic [31:0]      rd;
        logic [NR*32-1:0] rg;
        logic             done;
        rdata = 32'h0;
        err   = 1'b0;
        waits = 0;
        done  = 1'b0;
        @(posedge clk); #1;
        drive(d, 1'b1, 1'b0, wr, addr, wdata);
        @(posedge clk); #1;
        drive(d, 1'b1, 1'b1, wr, addr, wdata);
        for (int n = 0; n < 20 && !done; n++) begin
            @(negedge clk);
            sample(d, rdy, rd, e, st, rg);
            if (rdy) begin
                rdata = rd;
                err   = e;
                done  = 1'b1;
            end else begin
                waits++;
                @(posedge clk); #1;
            end
        end
        check("xfer_completed", {31'b0, done}, 32'h1);
    endtask

    task automatic bus_idle(input int d);
        @(posedge clk); #1;
        drive(d, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    initial begin
        logic [31:0]      rd;
        logic             err, rdy, st;
        logic [NR*32-1:0] rg;
        int               w;
        int               t0;

        rst = 1'b1;
        for (int d = 0; d < 3; d++) drive(d, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        sample(0, rdy, rd, err, st, rg);
        check("rst_pready", {31'b0, rdy}, 32'h0);
        check("rst_prdata", rd, 32'h0);
        check("rst_pslverr", {31'b0, err}, 32'h0);
        check("rst_state", {31'b0, st}, 32'h0);
        check("rst_slot0", rg[31:0], ID);
        check("rst_slot1", rg[63:32], 32'h0);

        // WAIT_STATES=0: write then read 0x04
        xfer(0, 1'b1, 32'h04, 32'hDEADBEEF, rd, err, w);
        check("ws0_wr_waits", 32'(w), 32'h0);
        check("ws0_wr_err", {31'b0, err}, 32'h0);
        xfer(0, 1'b0, 32'h04, 32'h0, rd, err, w);
        check("ws0_rd_waits", 32'(w), 32'h0);
        check("ws0_rd_data", rd, 32'hDEADBEEF);
        check("ws0_rd_err", {31'b0, err}, 32'h0);
        bus_idle(0);
        @(negedge clk);
        check("ws0_regs_slot1", regs0[63:32], 32'hDEADBEEF);

        // WAIT_STATES=3: read ID register
        xfer(1, 1'b0, 32'h00, 32'h0, rd, err, w);
        check("ws3_rd_waits", 32'(w), 32'h3);
        check("ws3_rd_data", rd, ID);
        check("ws3_rd_err", {31'b0, err}, 32'h0);
        bus_idle(1);

        // Write to ID register is rejected
        xfer(0, 1'b1, 32'h00, 32'h1234, rd, err, w);
        check("id_wr_err", {31'b0, err}, 32'h1);
        xfer(0, 1'b0, 32'h00, 32'h0, rd, err, w);
        check("id_rd_data", rd, ID);
        check("id_rd_err", {31'b0, err}, 32'h0);

        // Out-of-range read, misaligned write
        xfer(0, 1'b0, 32'h20, 32'h0, rd, err, w);
        check("oor_rd_err", {31'b0, err}, 32'h1);
        check("oor_rd_data", rd, 32'h0);
        xfer(0, 1'b1, 32'h06, 32'hFFFF_FFFF, rd, err, w);
        check("mis_wr_err", {31'b0, err}, 32'h1);
        bus_idle(0);
        @(negedge clk);
        check("mis_slot0", regs0[31:0], ID);
        check("mis_slot1", regs0[63:32], 32'hDEADBEEF);
        for (int k = 2; k < NR; k++) check($sformatf("mis_slot%0d", k), regs0[32*k +: 32], 32'h0);

        // Setup phase skipped: protocol violation
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, 1'b1, 32'h14, 32'hAB);
        @(negedge clk);
        sample(0, rdy, rd, err, st, rg);
        check("viol_pready", {31'b0, rdy}, 32'h1);
        check("viol_pslverr", {31'b0, err}, 32'h1);
        bus_idle(0);
        @(negedge clk);
        sample(0, rdy, rd, err, st, rg);
        check("viol_state", {31'b0, st}, 32'h0);
        check("viol_slot5", rg[191:160], 32'h0);

        // Back-to-back writes then reads
        @(negedge clk);
        t0 = cyc;
        xfer(0, 1'b1, 32'h0C, 32'h1, rd, err, w);
        check("b2b_wr1_waits", 32'(w), 32'h0);
        xfer(0, 1'b1, 32'h10, 32'h2, rd, err, w);
        check("b2b_wr2_waits", 32'(w), 32'h0);
        check("b2b_cycles", 32'(cyc - t0), 32'h4);
        xfer(0, 1'b0, 32'h0C, 32'h0, rd, err, w);
        check("b2b_rd1", rd, 32'h1);
        xfer(0, 1'b0, 32'h10, 32'h0, rd, err, w);
        check("b2b_rd2", rd, 32'h2);
        bus_idle(0);
        @(negedge clk);
        check("b2b_slot3", regs0[127:96], 32'h1);
        check("b2b_slot4", regs0[159:128], 32'h2);

        // Abort by dropping psel mid-access (WAIT_STATES=3)
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b0, 1'b1, 32'h08, 32'h99);
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b1, 1'b1, 32'h08, 32'h99);
        @(negedge clk);
        sample(1, rdy, rd, err, st, rg);
        check("abort_pready", {31'b0, rdy}, 32'h0);
        bus_idle(1);
        @(posedge clk); #1;
        @(negedge clk);
        sample(1, rdy, rd, err, st, rg);
        check("abort_state", {31'b0, st}, 32'h0);
        check("abort_slot2", rg[95:64], 32'h0);

        // Reset in the first access cycle (WAIT_STATES=2)
        xfer(2, 1'b1, 32'h0C, 32'h77, rd, err, w);
        check("ws2_wr_waits", 32'(w), 32'h2);
        @(posedge clk); #1;
        drive(2, 1'b1, 1'b0, 1'b1, 32'h08, 32'h55);
        @(negedge clk);
        check("pre_rst_slot3", regs2[127:96], 32'h77);
        @(posedge clk); #1;
        drive(2, 1'b1, 1'b1, 1'b1, 32'h08, 32'h55);
        rst = 1'b1;
        @(negedge clk);
        sample(2, rdy, rd, err, st, rg);
        check("in_rst_pready", {31'b0, rdy}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(2, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        sample(2, rdy, rd, err, st, rg);
        check("post_rst_pready", {31'b0, rdy}, 32'h0);
        check("post_rst_prdata", rd, 32'h0);
        check("post_rst_pslverr", {31'b0, err}, 32'h0);
        check("post_rst_state", {31'b0, st}, 32'h0);
        check("post_rst_slot0", rg[31:0], ID);
        for (int k = 1; k < NR; k++) check($sformatf("post_rst_slot%0d", k), rg[32*k +: 32], 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/apb_slave_regbank.md
Name: apb_slave_regbank

Overview:
APB completer (responder) holding a bank of 32-bit memory-mapped registers. It answers the PSEL/PENABLE/PWRITE/PADDR/PWDATA transfers issued by the team's APB master FSM. Wait states are programmable, and PSLVERR is signalled on illegal accesses. Register contents are exported in parallel so SoC logic can use them as control and status.

Parameters:
NUM_REGS, 8, number of 32-bit registers, indices 0..NUM_REGS-1 (must be >= 2).
ADDR_W, 32, width of i_paddr.
WAIT_STATES, 0, wait cycles inserted per transfer before PREADY asserts (0..15).
ID_VALUE, 32'hA9B0_0001, constant returned by read-only register 0.

Ports:
i_clk_apb  in  1  APB clock; all logic on rising edge.
i_rst_apb  in  1  synchronous active-high reset.
i_psel  in  1  peripheral select.
i_penable  in  1  access-phase strobe.
i_pwrite  in  1  1 = write, 0 = read.
i_paddr  in  ADDR_W  byte address.
i_pwdata  in  32  write data.
o_pready  out  1  transfer-complete / wait-state control.
o_prdata  out  32  read data, valid while o_pready=1 on a read.
o_pslverr  out  1  error response, valid while o_pready=1.
o_regs  out  NUM_REGS*32  flattened register contents; reg k at bits [32k+31:32k]; slot 0 = ID_VALUE.

Behaviour:
- Interface decision: one clock, i_clk_apb. Reset i_rst_apb is synchronous, active-high.
- Reset values:
  - state = IDLE, wait counter = 0.
  - o_pready = 0, o_prdata = 0, o_pslverr = 0.
  - registers 1..NUM_REGS-1 = 0.
  - Reset asserted mid-transfer aborts the transfer: no write commits, and all outputs are 0 on the next cycle.
- FSM states: IDLE, ACCESS.
  - IDLE, on i_psel=1 and i_penable=0 (setup phase):
    - latch i_paddr, i_pwrite, i_pwdata;
    - load wait counter with WAIT_STATES;
    - go to ACCESS.
  - ACCESS, i_psel=1, i_penable=1, counter != 0: o_pready=0, counter decrements, stay in ACCESS.
  - ACCESS, i_psel=1, i_penable=1, counter == 0 (completion cycle):
    - o_pready=1, driven combinationally from state and counter;
    - o_prdata and o_pslverr valid in the same cycle;
    - write commits at the clock edge ending this cycle;
    - next state IDLE. Back-to-back transfers re-enter through a new setup phase seen in IDLE.
  - ACCESS, i_psel=0: abort, return to IDLE, no write, o_pready=0.
- Latency: completion occurs in access cycle WAIT_STATES+1. With WAIT_STATES=0, PREADY is high in the first access cycle.
- Decode uses the latched address. Word index = paddr[ADDR_W-1:2].
  - Error if paddr[1:0] != 0: PSLVERR=1, no write, PRDATA=0.
  - Error if index >= NUM_REGS: PSLVERR=1, no write, PRDATA=0.
  - Error on a write to index 0 (ID register): PSLVERR=1, register unchanged.
  - Read of index 0 returns ID_VALUE with PSLVERR=0.
  - Valid read: PRDATA = reg[index]. Valid write: reg[index] <= latched pwdata.
- Outside the completion cycle: o_prdata = 0, o_pslverr = 0.
- Protocol violations:
  - i_psel=1 and i_penable=1 while in IDLE (no setup phase): respond o_pready=1, o_pslverr=1 that cycle; no write, stay IDLE.
  - Address, write or data changes during ACCESS are ignored; the latched values are used.
- o_regs reflects register state after the clock edge; a write is visible one cycle after the completion cycle.

Test Plan:
- WAIT_STATES=0: write 32'hDEADBEEF to 0x04, then read 0x04 -> PREADY high in the first access cycle of each transfer; read returns 32'hDEADBEEF with PSLVERR=0; o_regs[63:32]=32'hDEADBEEF.
- WAIT_STATES=3: read 0x00 -> PREADY low for 3 access cycles, high on the 4th; PRDATA=32'hA9B0_0001.
- Write 32'h1234 to 0x00 -> PSLVERR=1 on the completion cycle; a following read of 0x00 still returns 32'hA9B0_0001.
- Read 0x20 (NUM_REGS=8) -> PSLVERR=1, PRDATA=0. Write 0x06 -> PSLVERR=1, no register changes.
- Start a write of 32'h55 to 0x08 with WAIT_STATES=2, assert i_rst_apb in the first access cycle -> next cycle: PREADY=0, o_regs all 0 except slot 0; register 2 remains 0.
- Back-to-back: write 0x0C=32'h1, setup, write 0x10=32'h2, then read both -> reads return 1 and 2; no cycle is skipped or duplicated.
